lsu_ctrl_mo: RTL and testbench

//  Parametrised LSU control stage between AGU and DTCM. Supports up to OSTD_DP in-order

---
 rtl/lsu_ctrl_mo.sv | 121 ++++++++++++
 tb/tb_lsu_ctrl_mo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl_mo.sv
// lsu_ctrl_mo: LSU control stage between AGU and DTCM with in-order outstanding tracking
//   Ports:
//     clk, rst_n                     clock, asynchronous active-low reset
//     agu_cmd_*                      AGU request (valid/ready, read, addr, wdata, itag, usign, size)
//     dtcm_cmd_*                     DTCM request (word-aligned addr, lane-replicated wdata, byte mask)
//     dtcm_rsp_*                     DTCM response (in order, one per issued access)
//     lsu_o_valid/ready, lsu_o_wbck_* in-order writeback (aligned/extended data, itag, trap flag)
//     lsu_o_outs_cnt                 commands currently in flight
module lsu_ctrl_mo #(
    parameter int XLEN    = 32,
    parameter int AW      = 16,
    parameter int ITAG_W  = 2,
    parameter int OSTD_DP = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         agu_cmd_valid,
    output logic                         agu_cmd_ready,
    input  logic                         agu_cmd_read,
    input  logic [AW-1:0]                agu_cmd_addr,
    input  logic [XLEN-1:0]              agu_cmd_wdata,
    input  logic [ITAG_W-1:0]            agu_cmd_itag,
    input  logic                         agu_cmd_usign,
    input  logic [1:0]                   agu_cmd_size,
    output logic                         dtcm_cmd_valid,
    input  logic                         dtcm_cmd_ready,
    output logic                         dtcm_cmd_read,
    output logic [AW-1:0]                dtcm_cmd_addr,
    output logic [XLEN-1:0]              dtcm_cmd_wdata,
    output logic [XLEN/8-1:0]            dtcm_cmd_wmask,
    input  logic                         dtcm_rsp_valid,
    output logic                         dtcm_rsp_ready,
    input  logic [XLEN-1:0]              dtcm_rsp_rdata,
    output logic                         lsu_o_valid,
    input  logic                         lsu_o_ready,
    output logic [XLEN-1:0]              lsu_o_wbck_data,
    output logic [ITAG_W-1:0]            lsu_o_wbck_itag,
    output logic                         lsu_o_wbck_err,
    output logic [$clog2(OSTD_DP+1)-1:0] lsu_o_outs_cnt
);
    localparam int CW = $clog2(OSTD_DP + 1);
    localparam int PW = (OSTD_DP > 1) ? $clog2(OSTD_DP) : 1;

    typedef struct packed {
        logic [ITAG_W-1:0] itag;
        logic              read;
        logic              usign;
        logic [1:0]        size;
        logic [1:0]        off;
        logic              err;
    } info_t;

    info_t          fifo_q [OSTD_DP];
    info_t          head, entry;
    logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           full, nonempty, mis, push, pop;
    logic [3:0]     base_mask;
    logic [XLEN-1:0] shifted, ext;

    assign full     = cnt_q == CW'(OSTD_DP);
    assign nonempty = cnt_q != '0;
    assign head     = fifo_q[rptr_q];

    assign mis = (agu_cmd_size == 2'b11) | ((agu_cmd_size == 2'b01) & agu_cmd_addr[0])
               | ((agu_cmd_size == 2'b10) & (|agu_cmd_addr[1:0]));

    // Misaligned commands bypass DTCM entirely, so they only need FIFO space.
    assign agu_cmd_ready  = ~full & (mis | dtcm_cmd_ready);
    assign dtcm_cmd_valid = agu_cmd_valid & ~full & ~mis;
    assign push           = agu_cmd_valid & agu_cmd_ready;
    assign entry          = '{itag: agu_cmd_itag, read: agu_cmd_read, usign: agu_cmd_usign,
                              size: agu_cmd_size, off: agu_cmd_addr[1:0], err: mis};

    assign base_mask      = (agu_cmd_size == 2'b00) ? 4'b0001 : (agu_cmd_size == 2'b01) ? 4'b0011 : 4'b1111;
    assign dtcm_cmd_read  = agu_cmd_read;
    assign dtcm_cmd_addr  = {agu_cmd_addr[AW-1:2], 2'b00};
    assign dtcm_cmd_wmask = agu_cmd_read ? '0 : base_mask << agu_cmd_addr[1:0];
    assign dtcm_cmd_wdata = (agu_cmd_size == 2'b00) ? {4{agu_cmd_wdata[7:0]}}
                          : (agu_cmd_size == 2'b01) ? {2{agu_cmd_wdata[15:0]}} : agu_cmd_wdata;

    // Trapped heads retire without waiting for DTCM; others need the matching response.
    assign lsu_o_valid    = nonempty & (head.err | dtcm_rsp_valid);
    assign dtcm_rsp_ready = nonempty & ~head.err & lsu_o_ready;
    assign pop            = lsu_o_valid & lsu_o_ready;

    assign shifted = dtcm_rsp_rdata >> {head.off, 3'b000};
    assign ext     = (head.size == 2'b00) ? {{24{~head.usign & shifted[7]}}, shifted[7:0]}
                   : (head.size == 2'b01) ? {{16{~head.usign & shifted[15]}}, shifted[15:0]} : shifted;

    assign lsu_o_wbck_data = (lsu_o_valid & head.read & ~head.err) ? ext : '0;
    assign lsu_o_wbck_itag = lsu_o_valid ? head.itag : '0;
    assign lsu_o_wbck_err  = lsu_o_valid & head.err;
    assign lsu_o_outs_cnt  = cnt_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        if (push) wptr_d = (wptr_q == PW'(OSTD_DP - 1)) ? '0 : wptr_q + 1'b1;
        if (pop)  rptr_d = (rptr_q == PW'(OSTD_DP - 1)) ? '0 : rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= entry;
    end

    a_rsp_when_empty: assert property (@(posedge clk) disable iff (!rst_n) !(dtcm_rsp_valid && !nonempty));
endmodule

// File: tb/tb_lsu_ctrl_mo.sv
// tb_lsu_ctrl_mo: directed self-checking bench for lsu_ctrl_mo
module tb_lsu_ctrl_mo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        agu_cmd_valid, agu_cmd_ready, agu_cmd_read, agu_cmd_usign;
    logic [15:0] agu_cmd_addr;
    logic [31:0] agu_cmd_wdata;
    logic [1:0]  agu_cmd_itag, agu_cmd_size;
    logic        dtcm_cmd_valid, dtcm_cmd_ready, dtcm_cmd_read;
    logic [15:0] dtcm_cmd_addr;
    logic [31:0] dtcm_cmd_wdata;
    logic [3:0]  dtcm_cmd_wmask;
    logic        dtcm_rsp_valid, dtcm_rsp_ready;
    logic [31:0] dtcm_rsp_rdata;
    logic        lsu_o_valid, lsu_o_ready, lsu_o_wbck_err;
    logic [31:0] lsu_o_wbck_data;
    logic [1:0]  lsu_o_wbck_itag;
    logic [1:0]  lsu_o_outs_cnt;
    int vectors = 0;
    int miscompares = 0;

    lsu_ctrl_mo dut (
        .clk(clk), .rst_n(rst_n),
        .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready), .agu_cmd_read(agu_cmd_read),
        .agu_cmd_addr(agu_cmd_addr), .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_itag(agu_cmd_itag),
        .agu_cmd_usign(agu_cmd_usign), .agu_cmd_size(agu_cmd_size),
        .dtcm_cmd_valid(dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready), .dtcm_cmd_read(dtcm_cmd_read),
        .dtcm_cmd_addr(dtcm_cmd_addr), .dtcm_cmd_wdata(dtcm_cmd_wdata), .dtcm_cmd_wmask(dtcm_cmd_wmask),
        .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(dtcm_rsp_ready), .dtcm_rsp_rdata(dtcm_rsp_rdata),
        .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready), .lsu_o_wbck_data(lsu_o_wbck_data),
        .lsu_o_wbck_itag(lsu_o_wbck_itag), .lsu_o_wbck_err(lsu_o_wbck_err), .lsu_o_outs_cnt(lsu_o_outs_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] a, input logic [1:0] it, input logic us,
                           input logic [1:0] sz, input logic [31:0] rd, input logic [31:0] exp);
        @(negedge clk);
        agu_cmd_valid = 1'b1; agu_cmd_read = 1'b1; agu_cmd_addr = a;
        agu_cmd_itag = it; agu_cmd_usign = us; agu_cmd_size = sz; agu_cmd_wdata = '0;
        #1;
        chk("ld_cmd_valid", 32'(dtcm_cmd_valid), 32'd1);
        chk("ld_cmd_addr", 32'(dtcm_cmd_addr), 32'(a & 16'hFFFC));
        chk("ld_cmd_wmask", 32'(dtcm_cmd_wmask), 32'd0);
        @(negedge clk);
        agu_cmd_valid = 1'b0; dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = rd;
        #1;
        chk("ld_wb_valid", 32'(lsu_o_valid), 32'd1);
        chk("ld_wb_data", lsu_o_wbck_data, exp);
        chk("ld_wb_itag", 32'(lsu_o_wbck_itag), 32'(it));
        chk("ld_wb_err", 32'(lsu_o_wbck_err), 32'd0);
        chk("ld_rsp_ready", 32'(dtcm_rsp_ready), 32'd1);
        @(negedge clk);
        dtcm_rsp_valid = 1'b0;
        #1;
        chk("ld_cnt_after", 32'(lsu_o_outs_cnt), 32'd0);
    endtask

    task automatic do_store(input logic [15:0] a, input logic [1:0] sz, input logic [31:0] wd,
                            input logic [15:0] exp_a, input logic [3:0] exp_m, input logic [31:0] exp_d);
        @(negedge clk);
        agu_cmd_valid = 1'b1; agu_cmd_read = 1'b0; agu_cmd_addr = a;
        agu_cmd_itag = 2'd2; agu_cmd_usign = 1'b0; agu_cmd_size = sz; agu_cmd_wdata = wd;
        #1;
        chk("st_cmd_valid", 32'(dtcm_cmd_valid), 32'd1);
        chk("st_cmd_read", 32'(dtcm_cmd_read), 32'd0);
        chk("st_cmd_addr", 32'(dtcm_cmd_addr), 32'(exp_a));
        chk("st_cmd_wmask", 32'(dtcm_cmd_wmask), 32'(exp_m));
        chk("st_cmd_wdata", dtcm_cmd_wdata, exp_d);
        @(negedge clk);
        agu_cmd_valid = 1'b0; dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'hFFFF_FFFF;
        #1;
        chk("st_wb_valid", 32'(lsu_o_valid), 32'd1);
        chk("st_wb_data", lsu_o_wbck_data, 32'd0);
        chk("st_wb_itag", 32'(lsu_o_wbck_itag), 32'd2);
        @(negedge clk);
        dtcm_rsp_valid = 1'b0;
        #1;
        chk("st_cnt_after", 32'(lsu_o_outs_cnt), 32'd0);
    endtask

    task automatic do_trap(input logic [15:0] a, input logic [1:0] sz, input logic [1:0] it);
        @(negedge clk);
        agu_cmd_valid = 1'b1; agu_cmd_read = 1'b1; agu_cmd_addr = a;
        agu_cmd_itag = it; agu_cmd_size = sz; dtcm_cmd_ready = 1'b0;
        #1;
        chk("trap_no_dtcm", 32'(dtcm_cmd_valid), 32'd0);
        chk("trap_ready", 32'(agu_cmd_ready), 32'd1);
        chk("trap_wb_early", 32'(lsu_o_valid), 32'd0);
        @(negedge clk);
        agu_cmd_valid = 1'b0; dtcm_cmd_ready = 1'b1;
        #1;
        chk("trap_wb_valid", 32'(lsu_o_valid), 32'd1);
        chk("trap_wb_err", 32'(lsu_o_wbck_err), 32'd1);
        chk("trap_wb_data", lsu_o_wbck_data, 32'd0);
        chk("trap_wb_itag", 32'(lsu_o_wbck_itag), 32'(it));
        chk("trap_rsp_ready", 32'(dtcm_rsp_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("trap_cnt_after", 32'(lsu_o_outs_cnt), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        agu_cmd_valid = 1'b0; agu_cmd_read = 1'b0; agu_cmd_addr = '0; agu_cmd_wdata = '0;
        agu_cmd_itag = '0; agu_cmd_usign = 1'b0; agu_cmd_size = '0;
        dtcm_cmd_ready = 1'b1; dtcm_rsp_valid = 1'b0; dtcm_rsp_rdata = '0; lsu_o_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cnt", 32'(lsu_o_outs_cnt), 32'd0);
        chk("rst_wb_valid", 32'(lsu_o_valid), 32'd0);
        chk("rst_cmd_valid", 32'(dtcm_cmd_valid), 32'd0);
        chk("rst_wb_data", lsu_o_wbck_data, 32'd0);
        chk("rst_wb_err", 32'(lsu_o_wbck_err), 32'd0);
        rst_n = 1'b1;

        do_load(16'h0003, 2'd1, 1'b0, 2'b00, 32'h80FF_1234, 32'hFFFF_FF80);
        do_load(16'h0002, 2'd2, 1'b1, 2'b01, 32'h8001_0000, 32'h0000_8001);
        do_load(16'h0002, 2'd3, 1'b0, 2'b01, 32'h8001_0000, 32'hFFFF_8001);
        do_load(16'h0001, 2'd0, 1'b1, 2'b00, 32'h0000_C300, 32'h0000_00C3);
        do_load(16'h0008, 2'd1, 1'b0, 2'b10, 32'h8765_4321, 32'h8765_4321);

        do_store(16'h0001, 2'b00, 32'h0000_00A5, 16'h0000, 4'b0010, 32'hA5A5_A5A5);
        do_store(16'h0002, 2'b01, 32'h0000_1234, 16'h0000, 4'b1100, 32'h1234_1234);
        do_store(16'h0004, 2'b10, 32'hDEAD_BEEF, 16'h0004, 4'b1111, 32'hDEAD_BEEF);

        do_trap(16'h0006, 2'b10, 2'd3);
        do_trap(16'h0001, 2'b01, 2'd1);
        do_trap(16'h0000, 2'b11, 2'd2);

        // three back-to-back word loads against a slow DTCM
        @(negedge clk);
        agu_cmd_valid = 1'b1; agu_cmd_read = 1'b1; agu_cmd_size = 2'b10; agu_cmd_usign = 1'b0;
        agu_cmd_addr = 16'h0000; agu_cmd_itag = 2'd0;
        #1;
        chk("b2b_rdy0", 32'(agu_cmd_ready), 32'd1);
        @(negedge clk);
        agu_cmd_addr = 16'h0004; agu_cmd_itag = 2'd1;
        #1;
        chk("b2b_rdy1", 32'(agu_cmd_ready), 32'd1);
        chk("b2b_cnt1", 32'(lsu_o_outs_cnt), 32'd1);
        @(negedge clk);
        agu_cmd_addr = 16'h0008; agu_cmd_itag = 2'd2;
        #1;
        chk("b2b_held", 32'(agu_cmd_ready), 32'd0);
        chk("b2b_held_dtcm", 32'(dtcm_cmd_valid), 32'd0);
        chk("b2b_cnt2", 32'(lsu_o_outs_cnt), 32'd2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("b2b_wait_held", 32'(agu_cmd_ready), 32'd0);
            chk("b2b_wait_cnt", 32'(lsu_o_outs_cnt), 32'd2);
        end
        @(negedge clk);
        dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'h1111_1111;
        #1;
        chk("b2b_ret0_itag", 32'(lsu_o_wbck_itag), 32'd0);
        chk("b2b_ret0_data", lsu_o_wbck_data, 32'h1111_1111);
        chk("b2b_full_pop_rdy", 32'(agu_cmd_ready), 32'd0);
        @(negedge clk);
        dtcm_rsp_rdata = 32'h2222_2222;
        #1;
        chk("b2b_cnt_after_pop", 32'(lsu_o_outs_cnt), 32'd1);
        chk("b2b_rdy_after_pop", 32'(agu_cmd_ready), 32'd1);
        chk("b2b_ret1_itag", 32'(lsu_o_wbck_itag), 32'd1);
        chk("b2b_ret1_data", lsu_o_wbck_data, 32'h2222_2222);
        @(negedge clk);
        agu_cmd_valid = 1'b0; dtcm_rsp_rdata = 32'h3333_3333;
        #1;
        chk("b2b_cnt_push_pop", 32'(lsu_o_outs_cnt), 32'd1);
        chk("b2b_ret2_itag", 32'(lsu_o_wbck_itag), 32'd2);
        chk("b2b_ret2_data", lsu_o_wbck_data, 32'h3333_3333);
        @(negedge clk);
        dtcm_rsp_valid = 1'b0;
        #1;
        chk("b2b_cnt_end", 32'(lsu_o_outs_cnt), 32'd0);

        // writeback backpressure with a response pending
        @(negedge clk);
        agu_cmd_valid = 1'b1; agu_cmd_addr = 16'h0010; agu_cmd_itag = 2'd1; agu_cmd_size = 2'b10;
        @(negedge clk);
        agu_cmd_valid = 1'b0; dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'hCAFE_F00D; lsu_o_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("bp_rsp_ready", 32'(dtcm_rsp_ready), 32'd0);
            chk("bp_wb_valid", 32'(lsu_o_valid), 32'd1);
            chk("bp_cnt", 32'(lsu_o_outs_cnt), 32'd1);
        end
        @(negedge clk);
        lsu_o_ready = 1'b1;
        #1;
        chk("bp_rsp_ready_rel", 32'(dtcm_rsp_ready), 32'd1);
        chk("bp_wb_data", lsu_o_wbck_data, 32'hCAFE_F00D);
        chk("bp_wb_itag", 32'(lsu_o_wbck_itag), 32'd1);
        @(negedge clk);
        dtcm_rsp_valid = 1'b0;
        #1;
        chk("bp_cnt_end", 32'(lsu_o_outs_cnt), 32'd0);

        // reset while two loads are in flight
        @(negedge clk);
        agu_cmd_valid = 1'b1; agu_cmd_addr = 16'h0000; agu_cmd_itag = 2'd0;
        @(negedge clk);
        agu_cmd_addr = 16'h0004; agu_cmd_itag = 2'd1;
        @(negedge clk);
        agu_cmd_valid = 1'b0;
        #1;
        chk("mid_cnt_before", 32'(lsu_o_outs_cnt), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", 32'(lsu_o_outs_cnt), 32'd0);
        chk("mid_rst_wb_valid", 32'(lsu_o_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_cnt", 32'(lsu_o_outs_cnt), 32'd0);
        chk("post_rst_rdy", 32'(agu_cmd_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
